// File: rtl/elevator_door_controller.sv
// Purpose : elevator door sequencer (open / dwell / close) with position tracking, reversal and move permission.
// Latency : a request sampled on edge n drives motor_open from edge n; outputs are a decode of registered state.
// Backpres: none; level inputs are sampled every clock, and arrived is not queued outside CLOSED.
//
// Ports:
//   clk, rst_n            - door-rate clock, asynchronous active-low reset
//   arrived               - one-cycle pulse when the car stops at a floor
//   car_stopped           - car is stationary (qualifies open_btn)
//   open_btn, close_btn   - level door requests
//   obstruction           - doorway sensor, level
//   weight_limit_exceeded - overload, level (holds the door open, blocks motion)
//   motor_open/close      - door motor drive, never both high
//   door_closed           - door fully closed
//   move_enable           - car may move (closed and load legal)
//   door_pos              - 0 = closed, TRAVEL_TIME = fully open
//   reopen_cnt            - saturating count of closing reversals
module elevator_door_controller #(
  parameter int unsigned TRAVEL_TIME = 4,
  parameter int unsigned HOLD_TIME   = 6,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arrived,
  input  logic             car_stopped,
  input  logic             open_btn,
  input  logic             close_btn,
  input  logic             obstruction,
  input  logic             weight_limit_exceeded,
  output logic             motor_open,
  output logic             motor_close,
  output logic             door_closed,
  output logic             move_enable,
  output logic [CNT_W-1:0] door_pos,
  output logic [7:0]       reopen_cnt
);

  typedef enum logic [1:0] {
    CLOSED    = 2'd0,
    OPENING   = 2'd1,
    OPEN_HOLD = 2'd2,
    CLOSING   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] POS_OPEN   = CNT_W'(TRAVEL_TIME);
  localparam logic [CNT_W-1:0] POS_LAST   = CNT_W'(TRAVEL_TIME - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             req_open;
  logic             keep;

  assign req_open = arrived | (open_btn & car_stopped);
  assign keep     = open_btn | obstruction | weight_limit_exceeded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLOSED;
      door_pos   <= '0;
      hold_cnt   <= '0;
      reopen_cnt <= '0;
    end else begin
      case (state)
        CLOSED: begin
          if (req_open) begin
            state <= OPENING;
          end
        end

        OPENING: begin
          // >= rather than == : a reversal taken at the fully-open position
          // re-enters OPENING at TRAVEL_TIME and must not overshoot.
          if (door_pos >= POS_LAST) begin
            door_pos <= POS_OPEN;
            hold_cnt <= '0;
            state    <= OPEN_HOLD;
          end else begin
            door_pos <= door_pos + CNT_ONE;
          end
        end

        OPEN_HOLD: begin
          if (keep) begin
            hold_cnt <= '0;
          end else if (close_btn || (hold_cnt >= HOLD_LAST)) begin
            state <= CLOSING;
          end else begin
            hold_cnt <= hold_cnt + CNT_ONE;
          end
        end

        CLOSING: begin
          if (keep) begin
            // Reverse from the current position; the position holds this edge.
            state <= OPENING;
            if (reopen_cnt != 8'hFF) begin
              reopen_cnt <= reopen_cnt + 8'd1;
            end
          end else if (door_pos <= CNT_ONE) begin
            door_pos <= '0;
            state    <= CLOSED;
          end else begin
            door_pos <= door_pos - CNT_ONE;
          end
        end

        default: begin
          state <= CLOSED;
        end
      endcase
    end
  end

  assign motor_open  = (state == OPENING);
  assign motor_close = (state == CLOSING);
  assign door_closed = (state == CLOSED);
  assign move_enable = (state == CLOSED) & ~weight_limit_exceeded;

endmodule
